// File: rtl/emsg_pkg.sv
// Field layout of the compressed check-node message, shared by the generator and the expander.
package emsg_pkg;
  localparam int unsigned W  = 6;
  localparam int unsigned WC = 18;
  localparam int unsigned IW = 5;
  localparam int unsigned MW = W - 1;
  localparam int unsigned CW = 2 * MW + IW + WC;

  localparam int unsigned MIN1_LSB = 0;
  localparam int unsigned MIN2_LSB = MW;
  localparam int unsigned IDX_LSB  = 2 * MW;
  localparam int unsigned SGN_LSB  = 2 * MW + IW;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_EMIT = 1'b1;

  typedef struct packed {
    logic [WC-1:0] signs;
    logic [IW-1:0] idx;
    logic [MW-1:0] min2;
    logic [MW-1:0] min1;
  } comp_t;

  function automatic comp_t unpack_comp(input logic [CW-1:0] v);
    comp_t c;
    c.min1  = v[MIN1_LSB +: MW];
    c.min2  = v[MIN2_LSB +: MW];
    c.idx   = v[IDX_LSB +: IW];
    c.signs = v[SGN_LSB +: WC];
    return c;
  endfunction
endpackage

// File: rtl/emsg_mag_sel.sv
// Rebuilds one sign-magnitude extrinsic message from the min1/min2 pair with offset correction.
module emsg_mag_sel
  import emsg_pkg::*;
(
  input  logic [MW-1:0] min1,
  input  logic [MW-1:0] min2,
  input  logic [IW-1:0] idx,
  input  logic [IW-1:0] col,
  input  logic          sgn,
  input  logic [MW-1:0] ofs,
  output logic [W-1:0]  msg
);
  logic [MW-1:0] sel;
  logic [MW-1:0] mag;

  // col never reaches WC, so an out-of-range idx naturally selects min1 everywhere
  always_comb begin
    sel = (col == idx) ? min2 : min1;
    mag = (sel > ofs) ? (sel - ofs) : '0;
    msg = {sgn & (mag != '0), mag};
  end
endmodule

// File: rtl/emsg_expand.sv
// Serial expander: one compressed check word in, WC sign-magnitude messages out, one column per beat.
module emsg_expand
  import emsg_pkg::*;
#(
  parameter logic [MW-1:0] OFS = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CW-1:0] in_comp,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [W-1:0]  out_msg,
  output logic [IW-1:0] out_col,
  output logic          out_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          idx_err
);
  logic [0:0]    state_q, state_d;
  logic [IW-1:0] c_q, c_d;
  comp_t         hold_q, hold_d;
  logic          idx_err_q, idx_err_d;
  logic          emit, at_last, accept;
  comp_t         in_w;
  logic [W-1:0]  msg;

  assign in_w = unpack_comp(in_comp);

  // Next state: advance on accepted beats, reload on a new word (possibly on the last beat)
  always_comb begin
    state_d   = state_q;
    c_d       = c_q;
    hold_d    = hold_q;
    idx_err_d = idx_err_q;
    emit      = (state_q == S_EMIT);
    at_last   = (c_q == IW'(WC - 1));
    in_ready  = !emit || (at_last && out_ready);
    accept    = in_valid && in_ready;
    if (emit && out_ready) begin
      if (at_last) state_d = S_IDLE;
      else         c_d     = c_q + IW'(1);
    end
    if (accept) begin
      state_d = S_EMIT;
      c_d     = '0;
      hold_d  = in_w;
      if (in_w.idx >= IW'(WC)) idx_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      c_q       <= '0;
      hold_q    <= '0;
      idx_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      c_q       <= c_d;
      hold_q    <= hold_d;
      idx_err_q <= idx_err_d;
    end
  end

  emsg_mag_sel u_mag_sel (
    .min1 (hold_q.min1),
    .min2 (hold_q.min2),
    .idx  (hold_q.idx),
    .col  (c_q),
    .sgn  (hold_q.signs[c_q]),
    .ofs  (OFS),
    .msg  (msg)
  );

  assign out_valid = emit;
  assign out_msg   = emit ? msg : '0;
  assign out_col   = c_q;
  assign out_last  = emit && at_last;
  assign idx_err   = idx_err_q;
endmodule

// File: tb/tb_emsg_expand.sv
// Random and directed bench for emsg_expand; two instances (offset 0 and offset 2) share one stimulus.
module tb_emsg_expand;
  logic        clk, rst, in_valid, out_ready;
  logic [32:0] in_comp;
  logic        in_ready0, out_last0, out_valid0, idx_err0;
  logic        in_ready2, out_last2, out_valid2, idx_err2;
  logic [5:0]  out_msg0, out_msg2;
  logic [4:0]  out_col0, out_col2;

  emsg_expand #(.OFS(5'd0)) u_dut0 (
    .clk(clk), .rst(rst), .in_comp(in_comp), .in_valid(in_valid), .in_ready(in_ready0),
    .out_msg(out_msg0), .out_col(out_col0), .out_last(out_last0), .out_valid(out_valid0),
    .out_ready(out_ready), .idx_err(idx_err0));

  emsg_expand #(.OFS(5'd2)) u_dut2 (
    .clk(clk), .rst(rst), .in_comp(in_comp), .in_valid(in_valid), .in_ready(in_ready2),
    .out_msg(out_msg2), .out_col(out_col2), .out_last(out_last2), .out_valid(out_valid2),
    .out_ready(out_ready), .idx_err(idx_err2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] m0;
    logic [5:0] m2;
    logic [4:0] col;
  } beat_t;

  beat_t      q[$];
  logic [5:0] log0[$];
  logic [5:0] log2[$];
  int         total = 0;
  int         bad = 0;
  int         beats = 0;
  bit         mon_en = 0;
  bit         exp_err = 0;
  bit         rand_done = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference message straight from the min-sum rules
  function automatic logic [5:0] ref_msg(input logic [32:0] w, input int col, input int ofs);
    int min1, min2, idx, sel, mag;
    logic s;
    min1 = int'(w[4:0]);
    min2 = int'(w[9:5]);
    idx  = int'(w[14:10]);
    s    = w[15 + col];
    sel  = (idx == col) ? min2 : min1;
    mag  = sel - ofs;
    if (mag < 0) mag = 0;
    return (mag == 0) ? 6'd0 : {s, 5'(mag)};
  endfunction

  // Scoreboard: queue of expected beats, handshakes decided by the model itself
  always @(negedge clk) begin
    if (mon_en) begin
      bit    exp_valid, exp_rdy;
      beat_t b;
      exp_valid = (q.size() != 0);
      exp_rdy   = (q.size() == 0) || (q.size() == 1 && out_ready);
      chk("out_valid0", out_valid0, exp_valid);
      chk("out_valid2", out_valid2, exp_valid);
      chk("in_ready0", in_ready0, exp_rdy);
      chk("in_ready2", in_ready2, exp_rdy);
      chk("idx_err0", idx_err0, exp_err);
      chk("idx_err2", idx_err2, exp_err);
      if (exp_valid) begin
        chk("msg0", out_msg0, q[0].m0);
        chk("msg2", out_msg2, q[0].m2);
        chk("col0", out_col0, q[0].col);
        chk("col2", out_col2, q[0].col);
        chk("last0", out_last0, q[0].col == 5'd17);
        chk("last2", out_last2, q[0].col == 5'd17);
      end
      if (rst) begin
        q.delete();
        exp_err = 0;
      end else begin
        if (exp_valid && out_ready) begin
          log0.push_back(out_msg0);
          log2.push_back(out_msg2);
          void'(q.pop_front());
          beats++;
        end
        if (in_valid && exp_rdy) begin
          for (int c = 0; c < 18; c++) begin
            b.m0  = ref_msg(in_comp, c, 0);
            b.m2  = ref_msg(in_comp, c, 2);
            b.col = 5'(c);
            q.push_back(b);
          end
          if (in_comp[14:10] >= 5'd18) exp_err = 1;
        end
      end
    end
  end

  task automatic send(input logic [32:0] w, input bit keep);
    bit done = 0;
    in_comp  = w;
    in_valid = 1'b1;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (in_ready0) done = 1;
    end
    @(posedge clk); #1;
    if (!keep) in_valid = 1'b0;
    if (!done) chk("send_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk); #1;
      if (q.size() == 0) done = 1;
    end
    if (!done) chk("idle_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_col(input logic [4:0] col);
    bit done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      if (out_valid0 && out_col0 == col) done = 1;
      else begin
        @(posedge clk); #1;
      end
    end
    if (!done) chk("col_timeout", 0, 1);
  endtask

  initial begin
    #500000;
    bad++;
    $display("FAIL watchdog: got timeout expected completion at %0t", $time);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          l, n0;
    logic [32:0] w;
    rst = 1'b1; in_valid = 1'b0; in_comp = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1;
    chk("rst_msg", out_msg0, 6'h00);
    chk("rst_col", out_col0, 5'd0);
    chk("rst_last", out_last0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single word with the min2 column and two negative columns
    l = log0.size();
    send({18'h00021, 5'd4, 5'd9, 5'd3}, 0);
    wait_idle();
    chk("t1_beats", log0.size() - l, 18);
    chk("t1_col0", log0[l + 0], 6'h23);
    chk("t1_col1", log0[l + 1], 6'h03);
    chk("t1_col4", log0[l + 4], 6'h09);
    chk("t1_col5", log0[l + 5], 6'h23);
    chk("t1_col17", log0[l + 17], 6'h03);
    chk("t1_col0_ofs2", log2[l + 0], 6'h21);
    chk("t1_col4_ofs2", log2[l + 4], 6'h07);
    chk("t1_in_ready", in_ready0, 1'b1);

    // Back-to-back words with in_valid held high
    send({18'h15555, 5'd17, 5'd12, 5'd6}, 1);
    n0 = beats;
    send({18'h2AAAA, 5'd0, 5'd7, 5'd2}, 0);
    repeat (19) @(negedge clk);
    #1;
    chk("b2b_beats", beats - n0, 36);
    wait_idle();

    // Backpressure on column 7
    send({18'h0FF80, 5'd7, 5'd11, 5'd5}, 0);
    wait_col(5'd7);
    out_ready = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("bp_col", out_col0, 5'd7);
      chk("bp_msg", out_msg0, 6'h2b);
      chk("bp_rdy", in_ready0, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_next", out_col0, 5'd8);
    wait_idle();

    // Offset driving every magnitude to zero, all signs negative
    l = log2.size();
    send({18'h3FFFF, 5'd0, 5'd2, 5'd1}, 0);
    wait_idle();
    for (int i = 0; i < 18; i++) chk("ofs_zero", log2[l + i], 6'h00);
    chk("ofs0_col0", log0[l + 0], 6'h22);
    chk("ofs0_col1", log0[l + 1], 6'h21);

    // Out-of-range index: min1 everywhere, sticky error
    l = log0.size();
    send({18'h2AAAA, 5'd25, 5'd9, 5'd3}, 0);
    chk("idxerr_rise", idx_err0, 1'b1);
    wait_idle();
    for (int i = 0; i < 18; i += 5) begin
      logic [5:0] m;
      m = log0[l + i];
      chk("badidx_min1", m[4:0], 5'd3);
    end
    send({18'h00000, 5'd3, 5'd9, 5'd3}, 0);
    wait_idle();
    chk("idxerr_sticky", idx_err0, 1'b1);

    // Reset in the middle of a word
    send({18'h12345, 5'd2, 5'd8, 5'd4}, 0);
    wait_col(5'd10);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_valid", out_valid0, 1'b0);
    chk("mid_rst_ready", in_ready0, 1'b1);
    chk("mid_rst_err", idx_err0, 1'b0);
    l = log0.size();
    send({18'h00F0F, 5'd1, 5'd8, 5'd4}, 0);
    chk("post_rst_col", out_col0, 5'd0);
    wait_idle();
    chk("post_rst_beats", log0.size() - l, 18);

    // Randomized words with random backpressure and random gaps
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          bit gap;
          w[31:0]  = $urandom;
          w[32]    = 1'($urandom % 2);
          w[14:10] = 5'($urandom_range(0, 31));
          if ($urandom % 2 == 0) begin
            w[4:0] = 5'($urandom_range(0, 4));
            w[9:5] = 5'($urandom_range(0, 4));
          end
          gap = ($urandom % 3 == 0);
          send(w, !gap);
          if (gap) repeat ($urandom_range(1, 5)) @(posedge clk);
          #1;
        end
        in_valid = 1'b0;
        wait_idle();
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom % 4) != 0;
        end
        out_ready = 1'b1;
      end
    join

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/emsg_expand.md
Name: emsg_expand

Overview:
- Check-to-variable side of the min-sum LDPC check-node path. It is the decoder for the compressed extrinsic message that the check-node generator produces.
- Accepts one compressed word per check node over a valid/ready handshake. The word carries min1, min2, the min1 column index and the per-column extrinsic signs.
- Expands the word serially into wc sign-magnitude messages, one column per beat, with an optional offset-min-sum correction.
- Sits between the compressed check-message store and the variable-node update unit.

Parameters:
- w, 6: message width in bits; sign-magnitude, MSB is the sign, magnitude is w-1 bits.
- wc, 18: check-node degree, i.e. messages per compressed word.
- iw, 5: width of the min1 index field; must satisfy 2^iw >= wc.
- ofs, 0: offset subtracted from every magnitude, (w-1)-bit unsigned.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-high.
- in_comp  input  2*(w-1)+iw+wc  compressed word (33 bits at defaults):
  - [w-2:0] min1.
  - [2(w-1)-1:w-1] min2.
  - [2(w-1)+iw-1:2(w-1)] idx.
  - [top:2(w-1)+iw] signs; bit j is the sign of column j.
- in_valid  input  1  in_comp is valid.
- in_ready  output  1  block can accept a word this cycle.
- out_msg  output  w  expanded message, {sign, magnitude}.
- out_col  output  iw  column number of out_msg, 0..wc-1.
- out_last  output  1  high with column wc-1.
- out_valid  output  1  out_msg/out_col/out_last are valid.
- out_ready  input  1  downstream accepts this beat.
- idx_err  output  1  sticky flag, set when a word arrives with idx >= wc.

Behaviour:
- Reset (synchronous, rst=1 at posedge): out_valid=0, out_msg=0, out_col=0, out_last=0, idx_err=0, holding register cleared, state IDLE.
  - rst wins over every other event, including mid-word; the partially emitted word is discarded.
- States:
  - IDLE: out_valid=0, in_ready=1.
  - EMIT: out_valid=1 and a column counter c is active.
- Transitions:
  - IDLE with in_valid=1: latch in_comp, c<=0, go to EMIT. The first beat is presented the cycle after acceptance (latency 1).
  - EMIT with out_valid & out_ready: c<=c+1.
  - At c=wc-1 with the beat accepted:
    - if in_valid=1, latch the new word, c<=0, stay in EMIT. Back-to-back words have no bubble.
    - otherwise go to IDLE.
- in_ready = IDLE, or (EMIT and c=wc-1 and out_ready). This is combinational from state and out_ready.
- Backpressure: while out_valid=1 and out_ready=0, out_msg, out_col and out_last hold stable and c does not advance.
- Outputs are registered, or driven directly from registered state plus the holding register. There is no combinational in->out path.
- Magnitude select:
  - sel = min2 when c == idx, else min1.
  - If idx >= wc, every column uses min1, and idx_err is set at acceptance and stays set until rst.
- Offset: mag = sel - ofs when sel > ofs, else 0. Computed unsigned, width w-1, no wrap.
- Sign: sign = signs[c]. If mag == 0, sign is forced to 0, so out_msg = 0 and no negative zero is emitted.
- out_last = (c == wc-1).
- out_col = c; it wraps to 0 only on a new word.

Decomposition:
- Shared package emsg_pkg holds:
  - width constants W, WC, IW and derived CW = 2*(W-1)+IW+WC.
  - field offset constants MIN1_LSB, MIN2_LSB, IDX_LSB, SGN_LSB.
  - a packed struct typedef for the compressed word.
- The package is shared with the check-node generator so both ends agree on the field layout.
- One sub-module: emsg_mag_sel, combinational. Takes min1, min2, idx, c, sign bit and ofs; returns the w-bit message.
- The FSM, counter and holding register stay in the top.

Test Plan:
- Single word, out_ready=1: min1=3, min2=9, idx=4, signs=18'h00021, ofs=0.
  - Required: 18 beats starting the cycle after acceptance.
  - col0 = 6'b100011; col4 = 6'h09; col5 = 6'b100011; all other columns = 6'h03.
  - out_last only on col17; in_ready returns to 1.
- Back-to-back words with in_valid held high: the second word's col0 appears the cycle after the first word's col17, with no idle cycle. Exactly 36 beats are emitted over 37 cycles.
- Backpressure: deassert out_ready for 3 cycles at col7. Required: col7 data holds stable for all 3 cycles, in_ready=0, then col8 follows.
- Offset and zero: ofs=2, min1=1, min2=2, idx=0, signs all 1. Required: every beat is 6'h00 (no negative zero); col0 is also 0.
- Bad index: idx=25. Required: all 18 columns carry min1, idx_err rises the cycle after acceptance and stays high through subsequent good words.
- Reset at col10 mid-word. Required: the next cycle shows out_valid=0 and in_ready=1, a new word then starts at col0, and idx_err reads 0.
